// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register indices, ExcCodes, Cause field positions and the
// same-cycle request arbitration used by cp0_unit.
package cp0_pkg;

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;

  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_BREAK   = 5'd9;
  localparam logic [4:0] EXC_TEQ     = 5'd13;

  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_SW_LO  = 8;
  localparam int CAUSE_SW_HI  = 9;
  localparam int CAUSE_TI     = 15;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_EXC,
    OP_ERET,
    OP_MTC0
  } cp0_op_e;

  // Exactly one request wins per cycle; the others are discarded entirely.
  function automatic cp0_op_e resolve_op(input logic exc, input logic eret, input logic mtc0);
    cp0_op_e op;
    op = OP_NONE;
    if (exc)       op = OP_EXC;
    else if (eret) op = OP_ERET;
    else if (mtc0) op = OP_MTC0;
    return op;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer with a sticky match flag that feeds Cause[15].
// Only instantiated when CP0_TIMER_EN is defined.
module cp0_timer
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti_flag
);

  logic [31:0] count_reg;
  logic [31:0] compare_reg;
  logic        ti_flag_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg   <= '0;
      compare_reg <= '0;
      ti_flag_reg <= 1'b0;
    end else begin
      count_reg <= count_we ? wdata : count_reg + 32'd1;
      if (compare_we) compare_reg <= wdata;
      // Writing Compare acknowledges the interrupt, even against a same-cycle match.
      if (compare_we)
        ti_flag_reg <= 1'b0;
      else if ((compare_reg != 32'd0) && (count_reg == compare_reg))
        ti_flag_reg <= 1'b1;
    end
  end

  assign count   = count_reg;
  assign compare = compare_reg;
  assign ti_flag = ti_flag_reg;

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor-0 responder: Status/Cause/EPC, exception entry and eret bookkeeping.
// Optional Count/Compare timer interrupt is enabled by defining CP0_TIMER_EN.
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR  = 32'h0040_0004,
  parameter logic [31:0] STATUS_RST  = 32'h0000_000F,
  parameter int          STACK_SHIFT = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_cp0_mfc0,
  input  logic        cpu_cp0_mtc0,
  input  logic [4:0]  cpu_cp0_rd,
  input  logic [31:0] cpu_cp0_wdata,
  input  logic [31:0] cpu_cp0_pc,
  input  logic        cpu_cp0_exception,
  input  logic [4:0]  cpu_cp0_cause,
  input  logic        cpu_cp0_eret,
  output logic [31:0] cp0_cpu_rdata,
  output logic [31:0] cp0_cpu_status,
  output logic [31:0] cp0_cpu_exc_addr,
  output logic        cp0_cpu_intr
);

  logic [31:0] status_reg;
  logic [31:0] epc_reg;
  logic [4:0]  exc_code_reg;
  logic [1:0]  sw_ip_reg;
  logic [31:0] cause_word;
  logic [31:0] count_val;
  logic [31:0] compare_val;
  logic        ti_flag;
  logic        mtc0_en;
  cp0_op_e     op;

  assign op      = resolve_op(cpu_cp0_exception, cpu_cp0_eret, cpu_cp0_mtc0);
  assign mtc0_en = (op == OP_MTC0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      status_reg   <= STATUS_RST;
      epc_reg      <= '0;
      exc_code_reg <= '0;
      sw_ip_reg    <= '0;
    end else begin
      case (op)
        OP_EXC: begin
          epc_reg      <= cpu_cp0_pc;
          exc_code_reg <= cpu_cp0_cause;
          status_reg   <= status_reg << STACK_SHIFT;
        end
        OP_ERET: status_reg <= status_reg >> STACK_SHIFT;
        OP_MTC0: begin
          case (cpu_cp0_rd)
            REG_STATUS: status_reg <= cpu_cp0_wdata;
            REG_CAUSE:  sw_ip_reg  <= cpu_cp0_wdata[CAUSE_SW_HI:CAUSE_SW_LO];
            REG_EPC:    epc_reg    <= cpu_cp0_wdata;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

`ifdef CP0_TIMER_EN
  cp0_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .count_we   (mtc0_en && (cpu_cp0_rd == REG_COUNT)),
    .compare_we (mtc0_en && (cpu_cp0_rd == REG_COMPARE)),
    .wdata      (cpu_cp0_wdata),
    .count      (count_val),
    .compare    (compare_val),
    .ti_flag    (ti_flag)
  );
  assign cp0_cpu_intr = ti_flag & status_reg[0];
`else
  assign count_val    = '0;
  assign compare_val  = '0;
  assign ti_flag      = 1'b0;
  assign cp0_cpu_intr = 1'b0;
`endif

  // Only the architected Cause fields exist; everything else reads as zero.
  always_comb begin
    cause_word = '0;
    cause_word[CAUSE_TI] = ti_flag;
    cause_word[CAUSE_SW_HI:CAUSE_SW_LO] = sw_ip_reg;
    cause_word[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc_code_reg;
  end

  always_comb begin
    cp0_cpu_rdata = '0;
    if (cpu_cp0_mfc0) begin
      case (cpu_cp0_rd)
        REG_STATUS:  cp0_cpu_rdata = status_reg;
        REG_CAUSE:   cp0_cpu_rdata = cause_word;
        REG_EPC:     cp0_cpu_rdata = epc_reg;
        REG_COUNT:   cp0_cpu_rdata = count_val;
        REG_COMPARE: cp0_cpu_rdata = compare_val;
        default:     cp0_cpu_rdata = '0;
      endcase
    end
  end

  assign cp0_cpu_status   = status_reg;
  assign cp0_cpu_exc_addr = cpu_cp0_eret ? epc_reg : EXC_VECTOR;

endmodule

// File: tb/tb_cp0_unit.sv
// Scoreboard bench for cp0_unit: stimulus queues expected outputs, a negedge monitor
// pops and compares them whenever an observation is flagged.
module tb_cp0_unit;

  localparam logic [31:0] VEC = 32'h0040_0004;

  logic        clk;
  logic        reset;
  logic        mfc0, mtc0, exc, eret;
  logic [4:0]  rd, cause;
  logic [31:0] wdata, pc;
  logic [31:0] rdata, status, exc_addr;
  logic        intr;
  logic        obs;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic [31:0] status;
    logic [31:0] exc_addr;
    logic        intr;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  cp0_unit dut (
    .clk               (clk),
    .reset             (reset),
    .cpu_cp0_mfc0      (mfc0),
    .cpu_cp0_mtc0      (mtc0),
    .cpu_cp0_rd        (rd),
    .cpu_cp0_wdata     (wdata),
    .cpu_cp0_pc        (pc),
    .cpu_cp0_exception (exc),
    .cpu_cp0_cause     (cause),
    .cpu_cp0_eret      (eret),
    .cp0_cpu_rdata     (rdata),
    .cp0_cpu_status    (status),
    .cp0_cpu_exc_addr  (exc_addr),
    .cp0_cpu_intr      (intr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string nm, input string fld, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s.%s actual=0x%08h required=0x%08h", nm, fld, act, expv);
    end
  endtask

  // Monitor: independent of stimulus, consumes one expectation per flagged cycle.
  always @(negedge clk) begin
    if (obs) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL scoreboard_underflow actual=empty required=entry");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check32(e.name, "rdata", rdata, e.rdata);
        check32(e.name, "status", status, e.status);
        check32(e.name, "exc_addr", exc_addr, e.exc_addr);
        check32(e.name, "intr", {31'b0, intr}, {31'b0, e.intr});
        $display("[TB] %s rdata=0x%08h status=0x%08h exc_addr=0x%08h intr=%0b",
                 e.name, rdata, status, exc_addr, intr);
      end
    end
  end

  task automatic drive(input logic mf, input logic mt, input logic [4:0] r, input logic [31:0] wd,
                       input logic ex, input logic [4:0] cs, input logic [31:0] p, input logic er);
    mfc0 = mf; mtc0 = mt; rd = r; wdata = wd; exc = ex; cause = cs; pc = p; eret = er;
  endtask

  task automatic expect_now(input string nm, input logic [31:0] r, input logic [31:0] s,
                            input logic [31:0] ea, input logic i);
    exp_t e;
    e.name = nm; e.rdata = r; e.status = s; e.exc_addr = ea; e.intr = i;
    sb.push_back(e);
    obs = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    obs = 1'b0;
    drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0);
  endtask

  task automatic mfc0_chk(input string nm, input logic [4:0] r, input logic [31:0] r_exp,
                          input logic [31:0] s_exp, input logic i_exp);
    drive(1, 0, r, 32'd0, 0, 5'd0, 32'd0, 0);
    expect_now(nm, r_exp, s_exp, VEC, i_exp);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    obs = 1'b0;
    reset = 1'b0;
    drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0);
    tick(); tick();
    reset = 1'b1;

    expect_now("reset_state", 32'd0, 32'h0F, VEC, 1'b0);
    tick();

    // EPC write/read-back, unmapped index, mfc0 low
    drive(0, 1, 5'd14, 32'h1234_5678, 0, 5'd0, 32'd0, 0); tick();
    mfc0_chk("mfc0_epc", 5'd14, 32'h1234_5678, 32'h0F, 1'b0);
    mfc0_chk("mfc0_rd3", 5'd3, 32'd0, 32'h0F, 1'b0);
    drive(0, 0, 5'd14, 32'd0, 0, 5'd0, 32'd0, 0);
    expect_now("mfc0_low", 32'd0, 32'h0F, VEC, 1'b0);
    tick();

    // Cause write only touches the software IP bits
    drive(0, 1, 5'd13, 32'hFFFF_FFFF, 0, 5'd0, 32'd0, 0); tick();
    mfc0_chk("cause_sw_ip", 5'd13, 32'h0000_0300, 32'h0F, 1'b0);
    drive(0, 1, 5'd13, 32'd0, 0, 5'd0, 32'd0, 0); tick();

`ifndef CP0_TIMER_EN
    drive(0, 1, 5'd9, 32'd5, 0, 5'd0, 32'd0, 0); tick();
    mfc0_chk("count_absent", 5'd9, 32'd0, 32'h0F, 1'b0);
`endif

    // Exception entry then eret
    drive(0, 0, 5'd0, 32'd0, 1, 5'd8, 32'h0040_0100, 0);
    expect_now("exc_cycle", 32'd0, 32'h0F, VEC, 1'b0);
    tick();
    mfc0_chk("exc_epc", 5'd14, 32'h0040_0100, 32'h1E0, 1'b0);
    mfc0_chk("exc_cause", 5'd13, 32'h20, 32'h1E0, 1'b0);
    drive(1, 0, 5'd12, 32'd0, 0, 5'd0, 32'd0, 1);
    expect_now("eret_addr", 32'h1E0, 32'h1E0, 32'h0040_0100, 1'b0);
    tick();
    mfc0_chk("eret_status", 5'd12, 32'h0F, 32'h0F, 1'b0);

    // Exception beats mtc0
    drive(0, 1, 5'd12, 32'h0000_FFFF, 1, 5'd9, 32'h0040_0200, 0); tick();
    mfc0_chk("exc_over_mtc0", 5'd12, 32'h1E0, 32'h1E0, 1'b0);
    drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1); tick();
    // eret beats mtc0: EPC must keep its value
    drive(0, 1, 5'd14, 32'hDEAD_BEEF, 0, 5'd0, 32'd0, 1); tick();
    mfc0_chk("eret_over_mtc0", 5'd14, 32'h0040_0200, 32'h0, 1'b0);
    drive(0, 1, 5'd12, 32'h0F, 0, 5'd0, 32'd0, 0); tick();

    // Nested exceptions (second one also wins against a same-cycle eret)
    drive(0, 0, 5'd0, 32'd0, 1, 5'd13, 32'h0040_0300, 0); tick();
    drive(0, 0, 5'd0, 32'd0, 1, 5'd8, 32'h0040_0400, 1); tick();
    mfc0_chk("nest_status", 5'd12, 32'h3C00, 32'h3C00, 1'b0);
    mfc0_chk("nest_cause", 5'd13, 32'h20, 32'h3C00, 1'b0);
    drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1);
    expect_now("nest_eret1", 32'd0, 32'h3C00, 32'h0040_0400, 1'b0);
    tick();
    drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1);
    expect_now("nest_eret2", 32'd0, 32'h1E0, 32'h0040_0400, 1'b0);
    tick();
    mfc0_chk("nest_restored", 5'd12, 32'h0F, 32'h0F, 1'b0);

    // Asynchronous reset mid-cycle
    drive(0, 1, 5'd12, 32'h55, 0, 5'd0, 32'd0, 0); tick();
    drive(0, 1, 5'd14, 32'h99, 0, 5'd0, 32'd0, 0); tick();
    #1 reset = 1'b0;
    expect_now("async_reset", 32'd0, 32'h0F, VEC, 1'b0);
    tick();
    reset = 1'b1;
    mfc0_chk("reset_epc", 5'd14, 32'd0, 32'h0F, 1'b0);

`ifdef CP0_TIMER_EN
    drive(0, 1, 5'd11, 32'd10, 0, 5'd0, 32'd0, 0); tick();
    drive(0, 1, 5'd9, 32'd0, 0, 5'd0, 32'd0, 0); tick();
    for (int k = 0; k < 10; k++) tick();
    mfc0_chk("tmr_match", 5'd9, 32'd10, 32'h0F, 1'b0);
    mfc0_chk("tmr_cause", 5'd13, 32'h8000, 32'h0F, 1'b1);
    mfc0_chk("tmr_sticky", 5'd12, 32'h0F, 32'h0F, 1'b1);
    drive(0, 1, 5'd11, 32'd0, 0, 5'd0, 32'd0, 0);
    expect_now("tmr_clr_cycle", 32'd0, 32'h0F, VEC, 1'b1);
    tick();
    expect_now("tmr_cleared", 32'd0, 32'h0F, VEC, 1'b0);
    tick();
    drive(0, 1, 5'd9, 32'hFFFF_FFFF, 0, 5'd0, 32'd0, 0); tick();
    mfc0_chk("tmr_max", 5'd9, 32'hFFFF_FFFF, 32'h0F, 1'b0);
    mfc0_chk("tmr_wrap", 5'd9, 32'd0, 32'h0F, 1'b0);
`endif

    tick();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
